// File: rtl/dcache_mem_ctrl.sv
// ============================================================================
//  Module   : dcache_mem_ctrl
//  Purpose  : Data-cache memory-side controller. It services load misses
//             from the memory bus (or from the write-back buffer when the
//             line is still queued there), fills the line into the cache,
//             and buffers dirty victims in a small write-back FIFO that
//             drains to memory as bus stores.
//  Ports    : clock, reset (async, active-low)
//             miss_valid/miss_addr/miss_ready      - load-miss request
//             fill_done/fill_addr/fill_data        - fill notification
//             wr1_*                                - cache write/search side
//             evicted_*_in                         - victim line from cache
//             proc2mem_*                           - bus request
//             mem2proc_*                           - bus response / load data
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_mem_ctrl #(
    parameter int WB_DEPTH  = 2,
    parameter int MEM_TAG_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    // Miss request
    input  logic                 miss_valid,
    input  logic [63:0]          miss_addr,
    output logic                 miss_ready,
    // Fill notification
    output logic                 fill_done,
    output logic [63:0]          fill_addr,
    output logic [63:0]          fill_data,
    // Cache write side
    output logic                 wr1_en,
    output logic                 wr1_from_mem,
    output logic                 wr1_search,
    output logic                 wr1_dirty,
    output logic                 wr1_valid,
    output logic [63:0]          wr1_addr,
    output logic [63:0]          wr1_data,
    input  logic                 wr1_hit_in,
    input  logic                 evicted_valid_in,
    input  logic                 evicted_dirty_in,
    input  logic [63:0]          evicted_addr_in,
    input  logic [63:0]          evicted_data_in,
    // Memory bus
    output logic [1:0]           proc2mem_command,
    output logic [63:0]          proc2mem_addr,
    output logic [63:0]          proc2mem_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_response,
    input  logic [MEM_TAG_W-1:0] mem2proc_tag,
    input  logic [63:0]          mem2proc_data
);

    localparam int         c_PTR_W     = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int         c_CNT_W     = $clog2(WB_DEPTH + 1);
    localparam logic [1:0] c_BUS_NONE  = 2'd0;
    localparam logic [1:0] c_BUS_LOAD  = 2'd1;
    localparam logic [1:0] c_BUS_STORE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FILL = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_active;      // low until the first edge after reset
    logic [63:0]            r_line_addr;
    logic [63:0]            r_line_data;
    logic [MEM_TAG_W-1:0]   r_cur_tag;

    // Write-back FIFO
    logic [63:0]            r_wb_addr [WB_DEPTH];
    logic [63:0]            r_wb_data [WB_DEPTH];
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_CNT_W-1:0]     r_count;

    logic                   w_fifo_full;
    logic                   w_drain;
    logic                   w_resp_nz;
    logic                   w_pop;
    logic                   w_victim_dirty;
    logic                   w_stall;
    logic                   w_fill_fire;
    logic                   w_push;
    logic                   w_miss_fire;
    logic [63:0]            w_miss_line;
    logic                   w_fwd_hit;
    logic [63:0]            w_fwd_data;
    logic [c_PTR_W-1:0]     w_fwd_idx;
    logic                   w_unused;

    // Byte-offset bits of incoming addresses are deliberately dropped.
    assign w_unused = ^{miss_addr[2:0], evicted_addr_in[2:0]};

    assign w_miss_line    = {miss_addr[63:3], 3'b000};
    assign w_fifo_full    = (r_count == c_CNT_W'(WB_DEPTH));
    // The load request owns the bus while in REQ; otherwise the FIFO head drains.
    assign w_drain        = (r_count != '0) && (r_state != S_REQ);
    assign w_resp_nz      = |mem2proc_response;
    assign w_pop          = w_drain && w_resp_nz;
    assign w_victim_dirty = !wr1_hit_in && evicted_valid_in && evicted_dirty_in;
    // A pop in the same cycle frees the slot the victim needs, so no stall then.
    assign w_stall        = (r_state == S_FILL) && w_victim_dirty && w_fifo_full && !w_pop;
    assign w_fill_fire    = (r_state == S_FILL) && !w_stall;
    assign w_push         = w_fill_fire && w_victim_dirty;
    assign w_miss_fire    = (r_state == S_IDLE) && r_active && miss_valid;

    // Forwarding lookup: scan occupied slots oldest to youngest so that the
    // youngest copy of a line wins if it was evicted more than once.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_fwd_idx  = r_rd_ptr;
        for (int k = 0; k < WB_DEPTH; k++) begin
            w_fwd_idx = r_rd_ptr + c_PTR_W'(k);
            if ((c_CNT_W'(k) < r_count) &&
                (r_wb_addr[w_fwd_idx][63:3] == miss_addr[63:3])) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_wb_data[w_fwd_idx];
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_next     = r_state;
        miss_ready       = 1'b0;
        fill_done        = 1'b0;
        fill_addr        = '0;
        fill_data        = '0;
        wr1_en           = 1'b0;
        wr1_from_mem     = 1'b0;
        wr1_search       = 1'b0;
        wr1_dirty        = 1'b0;
        wr1_valid        = 1'b0;
        wr1_addr         = '0;
        wr1_data         = '0;
        proc2mem_command = c_BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;

        case (r_state)
            S_IDLE: begin
                miss_ready = r_active;
                if (w_miss_fire) begin
                    w_state_next = w_fwd_hit ? S_FILL : S_REQ;
                end
            end
            S_REQ: begin
                proc2mem_command = c_BUS_LOAD;
                proc2mem_addr    = r_line_addr;
                if (w_resp_nz) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // r_cur_tag is never zero here, so the idle tag value never matches.
                if (mem2proc_tag == r_cur_tag) begin
                    w_state_next = S_FILL;
                end
            end
            S_FILL: begin
                wr1_search = 1'b1;
                wr1_addr   = r_line_addr;
                if (!w_stall) begin
                    wr1_en       = 1'b1;
                    wr1_from_mem = 1'b1;
                    wr1_valid    = 1'b1;
                    wr1_data     = r_line_data;
                    fill_done    = 1'b1;
                    fill_addr    = r_line_addr;
                    fill_data    = r_line_data;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_drain) begin
            proc2mem_command = c_BUS_STORE;
            proc2mem_addr    = r_wb_addr[r_rd_ptr];
            proc2mem_data    = r_wb_data[r_rd_ptr];
        end
    end

    // Control state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_active    <= 1'b0;
            r_line_addr <= '0;
            r_line_data <= '0;
            r_cur_tag   <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state  <= w_state_next;
            r_active <= 1'b1;

            if (w_miss_fire) begin
                r_line_addr <= w_miss_line;
                if (w_fwd_hit) begin
                    r_line_data <= w_fwd_data;
                end
            end
            if ((r_state == S_REQ) && w_resp_nz) begin
                r_cur_tag <= mem2proc_response;
            end
            if ((r_state == S_WAIT) && (mem2proc_tag == r_cur_tag)) begin
                r_line_data <= mem2proc_data;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful below r_count, so no reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_wb_addr[r_wr_ptr] <= {evicted_addr_in[63:3], 3'b000};
            r_wb_data[r_wr_ptr] <= evicted_data_in;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dcache_mem_ctrl.sv
// ============================================================================
//  Module   : tb_dcache_mem_ctrl
//  Purpose  : Self-checking bench for dcache_mem_ctrl. A transaction-level
//             model (pending miss, bus tag, queue of victims) predicts every
//             output each cycle; directed scenarios additionally pin literal
//             values, followed by randomized traffic with occasional resets.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_mem_ctrl;

    localparam int         WB_DEPTH  = 2;
    localparam int         MEM_TAG_W = 4;
    localparam logic [1:0] c_NONE    = 2'd0;
    localparam logic [1:0] c_LOAD    = 2'd1;
    localparam logic [1:0] c_STORE   = 2'd2;

    localparam int F_READY = 0, F_CMD = 1, F_PADDR = 2, F_PDATA = 3, F_WEN = 4;
    localparam int F_FDONE = 5, F_WADDR = 6, F_WDATA = 7, F_WDIRTY = 8;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 miss_valid;
    logic [63:0]          miss_addr;
    logic                 miss_ready;
    logic                 fill_done;
    logic [63:0]          fill_addr;
    logic [63:0]          fill_data;
    logic                 wr1_en, wr1_from_mem, wr1_search, wr1_dirty, wr1_valid;
    logic [63:0]          wr1_addr;
    logic [63:0]          wr1_data;
    logic                 wr1_hit_in;
    logic                 evicted_valid_in, evicted_dirty_in;
    logic [63:0]          evicted_addr_in;
    logic [63:0]          evicted_data_in;
    logic [1:0]           proc2mem_command;
    logic [63:0]          proc2mem_addr;
    logic [63:0]          proc2mem_data;
    logic [MEM_TAG_W-1:0] mem2proc_response;
    logic [MEM_TAG_W-1:0] mem2proc_tag;
    logic [63:0]          mem2proc_data;

    always #5 clock = ~clock;

    dcache_mem_ctrl #(.WB_DEPTH(WB_DEPTH), .MEM_TAG_W(MEM_TAG_W)) dut (
        .clock(clock), .reset(reset),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .fill_done(fill_done), .fill_addr(fill_addr), .fill_data(fill_data),
        .wr1_en(wr1_en), .wr1_from_mem(wr1_from_mem), .wr1_search(wr1_search),
        .wr1_dirty(wr1_dirty), .wr1_valid(wr1_valid), .wr1_addr(wr1_addr),
        .wr1_data(wr1_data), .wr1_hit_in(wr1_hit_in),
        .evicted_valid_in(evicted_valid_in), .evicted_dirty_in(evicted_dirty_in),
        .evicted_addr_in(evicted_addr_in), .evicted_data_in(evicted_data_in),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wb_t;

    wb_t                  m_wb[$];          // queued victims, oldest first
    bit                   m_active  = 1'b0; // a clock edge has passed since reset
    bit                   m_pending = 1'b0; // a miss is being serviced
    bit                   m_got     = 1'b0; // line data is in hand
    logic [MEM_TAG_W-1:0] m_tag     = '0;   // bus tag of the outstanding load, 0 = none yet
    logic [63:0]          m_addr    = '0;
    logic [63:0]          m_data    = '0;

    int n_vec = 0;
    int n_err = 0;

    // Literal pins set by the stimulus for the current cycle
    bit          pin_use [9];
    logic [63:0] pin_val [9];
    string       pin_label = "";

    function automatic string fnm(input int f);
        case (f)
            F_READY: return "miss_ready";
            F_CMD:   return "command";
            F_PADDR: return "bus_addr";
            F_PDATA: return "bus_data";
            F_WEN:   return "wr1_en";
            F_FDONE: return "fill_done";
            F_WADDR: return "wr1_addr";
            F_WDATA: return "wr1_data";
            default: return "wr1_dirty";
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Compare process: outputs are sampled mid-cycle, then the model advances
    // by the effect of the coming rising edge (inputs are stable until then).
    always @(negedge clock) begin : b_cmp
        logic [1:0]  e_cmd;
        logic [63:0] e_paddr, e_pdata, e_waddr, e_wdata, e_faddr, e_fdata;
        logic        e_ready, e_fdone, e_wen, e_search, e_valid, e_from;
        logic [63:0] act [9];
        bit          req_ph, wait_ph, fill_ph, drain, pop, stall, vdirty;
        wb_t         ent;

        req_ph  = m_pending && !m_got && (m_tag == 0);
        wait_ph = m_pending && !m_got && (m_tag != 0);
        fill_ph = m_pending && m_got;
        e_cmd = c_NONE; e_paddr = '0; e_pdata = '0; e_waddr = '0; e_wdata = '0;
        e_faddr = '0; e_fdata = '0; e_ready = 0; e_fdone = 0; e_wen = 0;
        e_search = 0; e_valid = 0; e_from = 0;
        drain = 0; pop = 0; stall = 0; vdirty = 0;

        if (reset) begin
            e_ready = m_active && !m_pending;
            drain   = (m_wb.size() > 0) && !req_ph;
            if (req_ph) begin
                e_cmd = c_LOAD; e_paddr = m_addr;
            end
            if (drain) begin
                e_cmd = c_STORE; e_paddr = m_wb[0].addr; e_pdata = m_wb[0].data;
            end
            pop    = drain && (mem2proc_response != 0);
            vdirty = !wr1_hit_in && evicted_valid_in && evicted_dirty_in;
            stall  = vdirty && (m_wb.size() == WB_DEPTH) && !pop;
            if (fill_ph) begin
                e_search = 1; e_waddr = m_addr;
                if (!stall) begin
                    e_wen = 1; e_from = 1; e_valid = 1; e_wdata = m_data;
                    e_fdone = 1; e_faddr = m_addr; e_fdata = m_data;
                end
            end
        end

        chk("miss_ready",   64'(miss_ready),       64'(e_ready));
        chk("fill_done",    64'(fill_done),        64'(e_fdone));
        chk("fill_addr",    fill_addr,             e_faddr);
        chk("fill_data",    fill_data,             e_fdata);
        chk("wr1_en",       64'(wr1_en),           64'(e_wen));
        chk("wr1_from_mem", 64'(wr1_from_mem),     64'(e_from));
        chk("wr1_search",   64'(wr1_search),       64'(e_search));
        chk("wr1_dirty",    64'(wr1_dirty),        64'd0);
        chk("wr1_valid",    64'(wr1_valid),        64'(e_valid));
        chk("wr1_addr",     wr1_addr,              e_waddr);
        chk("wr1_data",     wr1_data,              e_wdata);
        chk("command",      64'(proc2mem_command), 64'(e_cmd));
        chk("bus_addr",     proc2mem_addr,         e_paddr);
        chk("bus_data",     proc2mem_data,         e_pdata);

        act[F_READY] = 64'(miss_ready);       act[F_CMD]   = 64'(proc2mem_command);
        act[F_PADDR] = proc2mem_addr;         act[F_PDATA] = proc2mem_data;
        act[F_WEN]   = 64'(wr1_en);           act[F_FDONE] = 64'(fill_done);
        act[F_WADDR] = wr1_addr;              act[F_WDATA] = wr1_data;
        act[F_WDIRTY] = 64'(wr1_dirty);
        for (int f = 0; f < 9; f++) begin
            if (pin_use[f]) chk({pin_label, ".", fnm(f)}, act[f], pin_val[f]);
        end

        // advance the model
        if (!reset) begin
            m_active = 0; m_pending = 0; m_got = 0; m_tag = '0;
            m_wb.delete();
        end else begin
            if (!m_pending && m_active && miss_valid) begin
                m_addr = miss_addr & ~64'h7;
                m_pending = 1; m_got = 0; m_tag = '0;
                for (int i = m_wb.size() - 1; i >= 0; i--) begin
                    if (m_wb[i].addr == m_addr) begin
                        m_data = m_wb[i].data; m_got = 1;
                        break;
                    end
                end
            end else if (req_ph && (mem2proc_response != 0)) begin
                m_tag = mem2proc_response;
            end else if (wait_ph && (mem2proc_tag == m_tag)) begin
                m_data = mem2proc_data; m_got = 1;
            end else if (fill_ph && !stall) begin
                m_pending = 0; m_got = 0; m_tag = '0;
            end
            if (pop) void'(m_wb.pop_front());
            if (fill_ph && !stall && vdirty) begin
                ent.addr = evicted_addr_in & ~64'h7;
                ent.data = evicted_data_in;
                m_wb.push_back(ent);
            end
            m_active = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
        for (int f = 0; f < 9; f++) pin_use[f] = 1'b0;
    endtask

    task automatic pin(input int f, input logic [63:0] v);
        pin_val[f] = v;
        pin_use[f] = 1'b1;
    endtask

    task automatic clr();
        miss_valid = 0; miss_addr = '0; wr1_hit_in = 0;
        evicted_valid_in = 0; evicted_dirty_in = 0;
        evicted_addr_in = '0; evicted_data_in = '0;
        mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    endtask

    task automatic victim(input logic [63:0] a, input logic [63:0] d);
        evicted_valid_in = 1; evicted_dirty_in = 1; wr1_hit_in = 0;
        evicted_addr_in = a; evicted_data_in = d;
    endtask

    // Miss serviced from memory: accept, response rsp, tag rsp next cycle.
    // Leaves the bench at the FILL cycle with inputs cleared.
    task automatic mem_miss(input logic [63:0] a, input logic [3:0] rsp, input logic [63:0] d);
        miss_valid = 1; miss_addr = a; cyc();
        miss_valid = 0; mem2proc_response = rsp; cyc();
        mem2proc_response = '0; mem2proc_tag = rsp; mem2proc_data = d; cyc();
        mem2proc_tag = '0;
    endtask

    initial begin
        for (int f = 0; f < 9; f++) begin
            pin_use[f] = 1'b0; pin_val[f] = '0;
        end
        reset = 0; clr();
        pin_label = "reset";
        pin(F_READY, 64'd0); pin(F_CMD, 64'(c_NONE)); cyc();
        reset = 1; pin(F_READY, 64'd0); cyc();
        pin(F_READY, 64'd1); cyc();

        // Clean miss, tag returns five cycles after the response
        pin_label = "clean";
        miss_valid = 1; miss_addr = 64'h1000; pin(F_READY, 64'd1); pin(F_CMD, 64'(c_NONE)); cyc();
        miss_valid = 0; mem2proc_response = 4'd3;
        pin(F_CMD, 64'(c_LOAD)); pin(F_PADDR, 64'h1000); cyc();
        mem2proc_response = '0;
        repeat (4) begin pin(F_CMD, 64'(c_NONE)); pin(F_WEN, 64'd0); cyc(); end
        mem2proc_tag = 4'd3; mem2proc_data = 64'hAAAA_AAAA_AAAA_AAAA; pin(F_WEN, 64'd0); cyc();
        mem2proc_tag = '0;
        pin(F_WEN, 64'd1); pin(F_FDONE, 64'd1); pin(F_WADDR, 64'h1000);
        pin(F_WDATA, 64'hAAAA_AAAA_AAAA_AAAA); pin(F_WDIRTY, 64'd0); pin(F_CMD, 64'(c_NONE)); cyc();
        pin(F_READY, 64'd1); pin(F_WEN, 64'd0); pin(F_CMD, 64'(c_NONE)); cyc();

        // Dirty eviction drains as a store
        pin_label = "evict";
        mem_miss(64'h1040, 4'd1, 64'hBEEF);
        victim(64'h2000, 64'h55); pin(F_WEN, 64'd1); pin(F_CMD, 64'(c_NONE)); cyc();
        clr(); pin(F_CMD, 64'(c_STORE)); pin(F_PADDR, 64'h2000); pin(F_PDATA, 64'h55); cyc();
        mem2proc_response = 4'd5; pin(F_CMD, 64'(c_STORE)); pin(F_PADDR, 64'h2000); cyc();
        mem2proc_response = '0; pin(F_CMD, 64'(c_NONE)); cyc();

        // Forwarding from the write-back FIFO while memory refuses
        pin_label = "fwd";
        mem_miss(64'h4000, 4'd1, 64'h4444);
        victim(64'h3000, 64'h77); pin(F_WEN, 64'd1); cyc();
        clr(); miss_valid = 1; miss_addr = 64'h3000;
        pin(F_READY, 64'd1); pin(F_CMD, 64'(c_STORE)); pin(F_PADDR, 64'h3000); cyc();
        miss_valid = 0;
        pin(F_WEN, 64'd1); pin(F_WDATA, 64'h77); pin(F_WDIRTY, 64'd0);
        pin(F_WADDR, 64'h3000); pin(F_CMD, 64'(c_STORE)); cyc();
        pin(F_CMD, 64'(c_STORE)); pin(F_PDATA, 64'h77); cyc();
        mem2proc_response = 4'd4; pin(F_CMD, 64'(c_STORE)); cyc();
        mem2proc_response = '0; pin(F_CMD, 64'(c_NONE)); pin(F_READY, 64'd1); cyc();

        // Full FIFO stall, then simultaneous pop and push
        pin_label = "full";
        mem_miss(64'h6000, 4'd7, 64'h66);
        victim(64'h5000, 64'h11); cyc();
        clr(); miss_valid = 1; miss_addr = 64'h7000; cyc();
        miss_valid = 0; mem2proc_response = 4'd8;
        pin(F_CMD, 64'(c_LOAD)); pin(F_PADDR, 64'h7000); cyc();
        mem2proc_response = '0; mem2proc_tag = 4'd8; cyc();
        mem2proc_tag = '0; victim(64'h8000, 64'h22); cyc();
        clr();
        mem_miss(64'h9000, 4'd9, 64'h99);
        victim(64'hA000, 64'h33);
        repeat (4) begin
            pin(F_WEN, 64'd0); pin(F_FDONE, 64'd0);
            pin(F_CMD, 64'(c_STORE)); pin(F_PADDR, 64'h5000); cyc();
        end
        mem2proc_response = 4'd2;
        pin(F_WEN, 64'd1); pin(F_FDONE, 64'd1); pin(F_WDATA, 64'h99);
        pin(F_CMD, 64'(c_STORE)); pin(F_PADDR, 64'h5000); cyc();
        evicted_valid_in = 0; evicted_dirty_in = 0;
        pin(F_CMD, 64'(c_STORE)); pin(F_PADDR, 64'h8000); pin(F_PDATA, 64'h22); cyc();
        pin(F_CMD, 64'(c_STORE)); pin(F_PADDR, 64'hA000); pin(F_PDATA, 64'h33); cyc();
        clr(); pin(F_CMD, 64'(c_NONE)); cyc();

        // Back-pressure on the load request, stray tags ignored
        pin_label = "bp";
        miss_valid = 1; miss_addr = 64'hB000; cyc();
        miss_valid = 0;
        repeat (3) begin pin(F_CMD, 64'(c_LOAD)); pin(F_PADDR, 64'hB000); cyc(); end
        mem2proc_response = 4'd2; pin(F_CMD, 64'(c_LOAD)); pin(F_PADDR, 64'hB000); cyc();
        mem2proc_response = '0; mem2proc_tag = 4'd1; pin(F_WEN, 64'd0); cyc();
        mem2proc_tag = 4'd7; pin(F_WEN, 64'd0); cyc();
        mem2proc_tag = 4'd2; mem2proc_data = 64'hB2; pin(F_WEN, 64'd0); cyc();
        mem2proc_tag = '0; pin(F_WEN, 64'd1); pin(F_WDATA, 64'hB2); cyc();

        // Reset while waiting for the load tag
        pin_label = "rst";
        miss_valid = 1; miss_addr = 64'hC000; cyc();
        miss_valid = 0; mem2proc_response = 4'd2; cyc();
        mem2proc_response = '0; cyc();
        reset = 0;
        pin(F_READY, 64'd0); pin(F_CMD, 64'(c_NONE)); pin(F_WEN, 64'd0); pin(F_FDONE, 64'd0); cyc();
        reset = 1; mem2proc_tag = 4'd2; mem2proc_data = 64'hDEAD;
        pin(F_READY, 64'd0); pin(F_WEN, 64'd0); cyc();
        mem2proc_tag = '0; pin(F_READY, 64'd1); pin(F_WEN, 64'd0); pin(F_FDONE, 64'd0); cyc();

        // Randomized traffic over a small address pool so forwarding occurs
        pin_label = "rand";
        for (int n = 0; n < 4000; n++) begin
            miss_valid = ($urandom_range(0, 2) == 0);
            miss_addr  = 64'h1000 * 64'($urandom_range(1, 6)) + 64'($urandom_range(0, 7));
            mem2proc_response = ($urandom_range(0, 9) < 3) ? MEM_TAG_W'($urandom_range(1, 15)) : '0;
            if ((m_tag != 0) && ($urandom_range(0, 3) == 0))
                mem2proc_tag = m_tag;
            else if ($urandom_range(0, 1) == 0)
                mem2proc_tag = MEM_TAG_W'($urandom_range(1, 15));
            else
                mem2proc_tag = '0;
            mem2proc_data    = {$urandom, $urandom};
            wr1_hit_in       = ($urandom_range(0, 3) == 0);
            evicted_valid_in = ($urandom_range(0, 3) != 0);
            evicted_dirty_in = ($urandom_range(0, 2) != 0);
            evicted_addr_in  = 64'h1000 * 64'($urandom_range(1, 6)) + 64'($urandom_range(0, 7));
            evicted_data_in  = {$urandom, $urandom};
            reset            = ($urandom_range(0, 399) != 0);
            cyc();
        end
        reset = 1; clr();
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
